// File: rtl/razr_pkg.sv
// Shared definitions for the razr bit-field slicer: mode encodings, counter width
// and small mode-decode helpers.
package razr_pkg;

  typedef enum logic [1:0] {
    RAZR_TRUNC   = 2'b00,
    RAZR_ROUND   = 2'b01,
    RAZR_SAT     = 2'b10,
    RAZR_SAT_ALT = 2'b11
  } razr_mode_e;

  localparam int RAZR_CNT_W = 16;

  // Every mode except plain truncation adds the half-LSB before shifting.
  function automatic logic mode_rounds(razr_mode_e m);
    return m != RAZR_TRUNC;
  endfunction

  // Both 10 and 11 saturate; only the upper mode bit matters.
  function automatic logic mode_sats(razr_mode_e m);
    return m[1];
  endfunction

endpackage

// File: rtl/razr_round_sat.sv
// Combinational range check of an IN_W+1 bit signed value against the signed
// OUT_W range, producing either the wrapped low bits or the clipped extreme.
module razr_round_sat
  import razr_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 12
) (
  input  logic [IN_W:0]    din,
  input  razr_mode_e       mode,
  output logic [OUT_W-1:0] dout,
  output logic             ovf
);

  // The value fits iff every bit from the OUT_W sign position upward agrees.
  logic [IN_W-OUT_W+1:0] top_bits;
  logic                  in_range;

  assign top_bits = din[IN_W:OUT_W-1];
  assign in_range = (top_bits == '0) || (top_bits == '1);

  always_comb begin
    ovf  = !in_range;
    dout = din[OUT_W-1:0];
    if (!in_range && mode_sats(mode)) begin
      dout = din[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/razr_slice_rs.sv
// Runtime-configurable narrowing slicer: signed IN_W samples are rounded/shifted
// in stage 1 and range-checked into OUT_W bits in stage 2, with an overflow counter.
module razr_slice_rs
  import razr_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 12,
  parameter int SHIFT_W   = 4,
  parameter int SHIFT_RST = IN_W - OUT_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [IN_W-1:0]       IN_D,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [SHIFT_W-1:0]    SHIFT,
  input  logic [1:0]            MODE,
  input  logic                  CFG_LD,
  output logic [OUT_W-1:0]      OUT_D,
  output logic                  OUT_OVF,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [RAZR_CNT_W-1:0] OVF_CNT,
  input  logic                  OVF_CLR
);

  localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(IN_W - 1);

  logic [SHIFT_W-1:0] cfg_shift;
  razr_mode_e         cfg_mode;

  logic [SHIFT_W:0]   shift_head;
  logic [SHIFT_W-1:0] shift_ld;

  logic               s1_valid;
  logic [IN_W:0]      s1_data;
  razr_mode_e         s1_mode;

  logic [IN_W:0]      ext;
  logic [IN_W:0]      rnd_add;
  logic [IN_W:0]      sum;
  logic [IN_W:0]      shifted;

  logic [OUT_W-1:0]   rs_d;
  logic               rs_ovf;

  logic               en1;
  logic               en2;

  // Handshake: a stage advances when it is empty or the stage after it advances;
  // a transfer happens on any edge where valid and ready are both high, and a
  // stage holding valid data keeps it (and its outputs) unchanged until then.
  // IN_READY is therefore combinational from OUT_READY.
  assign en2      = !OUT_VALID || OUT_READY;
  assign en1      = !s1_valid || en2;
  assign IN_READY = en1;

  // Clamp oversize shifts at load: a borrow out of MAX-SHIFT means SHIFT > MAX.
  assign shift_head = {1'b0, SHIFT_MAX} - {1'b0, SHIFT};
  assign shift_ld   = shift_head[SHIFT_W] ? SHIFT_MAX : SHIFT;

  always_comb begin
    ext     = {IN_D[IN_W-1], IN_D};
    rnd_add = '0;
    if (mode_rounds(cfg_mode) && (cfg_shift != '0)) begin
      rnd_add = (IN_W+1)'(1) << (cfg_shift - 1'b1);
    end
    sum     = ext + rnd_add;
    shifted = $signed(sum) >>> cfg_shift;
  end

  razr_round_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .din  (s1_data),
    .mode (s1_mode),
    .dout (rs_d),
    .ovf  (rs_ovf)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      cfg_shift <= SHIFT_W'(SHIFT_RST);
      cfg_mode  <= RAZR_TRUNC;
    end else if (CFG_LD) begin
      cfg_shift <= shift_ld;
      cfg_mode  <= razr_mode_e'(MODE);
    end
  end

  // Config is captured with each sample, so later loads never touch in-flight data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= RAZR_TRUNC;
    end else if (en1) begin
      s1_valid <= IN_VALID;
      if (IN_VALID) begin
        s1_data <= shifted;
        s1_mode <= cfg_mode;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      OUT_D     <= '0;
      OUT_OVF   <= 1'b0;
    end else if (en2) begin
      OUT_VALID <= s1_valid;
      if (s1_valid) begin
        OUT_D   <= rs_d;
        OUT_OVF <= rs_ovf;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || OVF_CLR) begin
      OVF_CNT <= '0;
    end else if (en2 && s1_valid && rs_ovf && !(&OVF_CNT)) begin
      OVF_CNT <= OVF_CNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_razr_slice_rs.sv
// Directed bench for razr_slice_rs at IN_W=16, OUT_W=12: one task per feature,
// hand-computed expected values, pass/total summary at the end.
module tb_razr_slice_rs;

  localparam int IN_W    = 16;
  localparam int OUT_W   = 12;
  localparam int SHIFT_W = 4;

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic [IN_W-1:0]    IN_D = '0;
  logic               IN_VALID = 1'b0;
  logic               IN_READY;
  logic [SHIFT_W-1:0] SHIFT = '0;
  logic [1:0]         MODE = '0;
  logic               CFG_LD = 1'b0;
  logic [OUT_W-1:0]   OUT_D;
  logic               OUT_OVF;
  logic               OUT_VALID;
  logic               OUT_READY = 1'b1;
  logic [15:0]        OVF_CNT;
  logic               OVF_CLR = 1'b0;

  int n_pass  = 0;
  int n_total = 0;
  logic [OUT_W-1:0] exp_q[$];

  razr_slice_rs #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_D      (IN_D),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .SHIFT     (SHIFT),
    .MODE      (MODE),
    .CFG_LD    (CFG_LD),
    .OUT_D     (OUT_D),
    .OUT_OVF   (OUT_OVF),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OVF_CNT   (OVF_CNT),
    .OVF_CLR   (OVF_CLR)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    IN_D      = '0;
    CFG_LD    = 1'b0;
    SHIFT     = '0;
    MODE      = '0;
    OVF_CLR   = 1'b0;
    OUT_READY = 1'b1;
    tick;
    tick;
    RST = 1'b0;
  endtask

  // driver tasks
  task automatic load_cfg(input logic [SHIFT_W-1:0] s, input logic [1:0] m);
    SHIFT  = s;
    MODE   = m;
    CFG_LD = 1'b1;
    tick;
    CFG_LD = 1'b0;
  endtask

  // Push one sample into an empty pipeline and wait (bounded) for it to appear.
  task automatic xfer(input logic [IN_W-1:0] d, output logic [OUT_W-1:0] od,
                      output logic oovf, output int lat);
    IN_D      = d;
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    tick;
    IN_VALID = 1'b0;
    lat = 1;
    while (!OUT_VALID && lat < 8) begin
      tick;
      lat++;
    end
    od   = OUT_D;
    oovf = OUT_OVF;
    if (!OUT_VALID) lat = -1;
    tick;
  endtask

  task automatic test_reset;
    logic [OUT_W-1:0] od;
    logic             ov;
    int               lat;
    do_reset;
    n_total++;
    if ({OUT_VALID, OUT_OVF, IN_READY, OUT_D, OVF_CNT} !== {1'b0, 1'b0, 1'b1, 12'h000, 16'h0000})
      $display("FAIL reset_state: got v=%b ovf=%b rdy=%b d=%h cnt=%h want v=0 ovf=0 rdy=1 d=000 cnt=0000",
               OUT_VALID, OUT_OVF, IN_READY, OUT_D, OVF_CNT);
    else n_pass++;
    xfer(16'h1234, od, ov, lat);
    n_total++;
    if ({ov, od} !== {1'b0, 12'h123}) $display("FAIL reset_cfg_1234: got ovf=%b d=%h want ovf=0 d=123", ov, od);
    else n_pass++;
    n_total++;
    if (lat !== 2) $display("FAIL latency: got %0d want 2", lat);
    else n_pass++;
    xfer(16'h8000, od, ov, lat);
    n_total++;
    if ({ov, od} !== {1'b0, 12'h800}) $display("FAIL reset_cfg_8000: got ovf=%b d=%h want ovf=0 d=800", ov, od);
    else n_pass++;
  endtask

  task automatic test_round;
    logic [IN_W-1:0]  vin [3];
    logic [OUT_W-1:0] vexp[3];
    logic [OUT_W-1:0] od;
    logic             ov;
    int               lat;
    vin  = '{16'h1238, 16'h1237, 16'hFFF8};
    vexp = '{12'h124, 12'h123, 12'h000};
    do_reset;
    load_cfg(4'd4, 2'b01);
    for (int i = 0; i < 3; i++) begin
      xfer(vin[i], od, ov, lat);
      n_total++;
      if ({ov, od} !== {1'b0, vexp[i]})
        $display("FAIL round_%h: got ovf=%b d=%h want ovf=0 d=%h", vin[i], ov, od, vexp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sat;
    logic [SHIFT_W-1:0] vsh [5];
    logic [1:0]         vmd [5];
    logic [IN_W-1:0]    vin [5];
    logic [OUT_W-1:0]   vexp[5];
    logic [OUT_W-1:0]   od;
    logic               ov;
    int                 lat;
    vsh  = '{4'd4, 4'd0, 4'd0, 4'd0, 4'd0};
    vmd  = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
    vin  = '{16'h7FF8, 16'h1234, 16'h8000, 16'h8000, 16'h1234};
    vexp = '{12'h7FF, 12'h7FF, 12'h800, 12'h800, 12'h234};
    do_reset;
    for (int i = 0; i < 5; i++) begin
      load_cfg(vsh[i], vmd[i]);
      xfer(vin[i], od, ov, lat);
      n_total++;
      if ({ov, od} !== {1'b1, vexp[i]})
        $display("FAIL sat_%0d: got ovf=%b d=%h want ovf=1 d=%h", i, ov, od, vexp[i]);
      else n_pass++;
      n_total++;
      if (OVF_CNT !== 16'(i + 1)) $display("FAIL sat_cnt_%0d: got %0d want %0d", i, OVF_CNT, i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_fill;
    int acc = 0;
    do_reset;
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      IN_D = 16'((acc + 1) << 4);
      #1;
      if (IN_READY) begin
        exp_q.push_back(12'(acc + 1));
        acc++;
      end
      tick;
    end
    IN_VALID = 1'b0;
    n_total++;
    if (acc !== 2 || IN_READY !== 1'b0) $display("FAIL fill_absorb: got acc=%0d rdy=%b want acc=2 rdy=0", acc, IN_READY);
    else n_pass++;
    OUT_READY = 1'b1;
    for (int c = 0; c < 6 && exp_q.size() != 0; c++) begin
      if (OUT_VALID) begin
        n_total++;
        if (OUT_D !== exp_q[0]) $display("FAIL fill_drain: got %h want %h", OUT_D, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
      end
      tick;
    end
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL fill_left: got %0d pending want 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int dlv_n = 0;
    int stall_acc = 0;
    logic acc, dlv;
    do_reset;
    load_cfg(4'd0, 2'b00);
    for (int cyc = 0; cyc < 60 && dlv_n < 10; cyc++) begin
      OUT_READY = !(cyc >= 5 && cyc < 10);
      IN_VALID  = (sent < 10);
      IN_D      = 16'(sent);
      #1;
      acc = IN_VALID && IN_READY;
      dlv = OUT_VALID && OUT_READY;
      if (!OUT_READY && acc) stall_acc++;
      if (cyc == 8) begin
        n_total++;
        if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1)
          $display("FAIL stall_full: got rdy=%b v=%b want rdy=0 v=1", IN_READY, OUT_VALID);
        else n_pass++;
      end
      if (cyc == 9 && exp_q.size() != 0) begin
        n_total++;
        if (OUT_D !== exp_q[0]) $display("FAIL stall_hold: got %h want %h", OUT_D, exp_q[0]);
        else n_pass++;
      end
      if (dlv) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL stream_extra: got %h want none", OUT_D);
        else if (OUT_D !== exp_q[0]) $display("FAIL stream_order: got %h want %h", OUT_D, exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        dlv_n++;
      end
      if (acc) begin
        exp_q.push_back(12'(sent));
        sent++;
      end
      tick;
    end
    IN_VALID = 1'b0;
    n_total++;
    if (dlv_n !== 10 || exp_q.size() !== 0 || stall_acc > 2)
      $display("FAIL stream_total: got dlv=%0d pend=%0d stall_acc=%0d want dlv=10 pend=0 stall_acc<=2",
               dlv_n, exp_q.size(), stall_acc);
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_cfg;
    logic [SHIFT_W-1:0] vsh [3];
    logic [1:0]         vmd [3];
    logic [IN_W-1:0]    vin [3];
    logic [OUT_W-1:0]   vexp[3];
    logic [OUT_W-1:0]   od;
    logic               ov;
    int                 lat;
    do_reset;
    IN_D      = 16'h0100;
    IN_VALID  = 1'b1;
    SHIFT     = 4'd2;
    MODE      = 2'b00;
    CFG_LD    = 1'b1;
    OUT_READY = 1'b1;
    tick;
    CFG_LD = 1'b0;
    tick;
    IN_VALID = 1'b0;
    n_total++;
    if ({OUT_VALID, OUT_D} !== {1'b1, 12'h010}) $display("FAIL cfg_old: got v=%b d=%h want v=1 d=010", OUT_VALID, OUT_D);
    else n_pass++;
    tick;
    n_total++;
    if ({OUT_VALID, OUT_D} !== {1'b1, 12'h040}) $display("FAIL cfg_new: got v=%b d=%h want v=1 d=040", OUT_VALID, OUT_D);
    else n_pass++;
    tick;
    vsh  = '{4'd15, 4'd15, 4'd15};
    vmd  = '{2'b00, 2'b00, 2'b01};
    vin  = '{16'h8000, 16'h7FFF, 16'h4000};
    vexp = '{12'hFFF, 12'h000, 12'h001};
    for (int i = 0; i < 3; i++) begin
      load_cfg(vsh[i], vmd[i]);
      xfer(vin[i], od, ov, lat);
      n_total++;
      if ({ov, od} !== {1'b0, vexp[i]})
        $display("FAIL shift15_%0d: got ovf=%b d=%h want ovf=0 d=%h", i, ov, od, vexp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    do_reset;
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    IN_D      = 16'h0500;
    tick;
    tick;
    IN_VALID = 1'b0;
    n_total++;
    if ({OUT_VALID, IN_READY} !== 2'b10) $display("FAIL mid_full: got v=%b rdy=%b want v=1 rdy=0", OUT_VALID, IN_READY);
    else n_pass++;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    n_total++;
    if ({OUT_VALID, IN_READY} !== 2'b01) $display("FAIL mid_reset: got v=%b rdy=%b want v=0 rdy=1", OUT_VALID, IN_READY);
    else n_pass++;
    OUT_READY = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (OUT_VALID) seen++;
      tick;
    end
    n_total++;
    if (seen !== 0) $display("FAIL mid_emit: got %0d outputs want 0", seen);
    else n_pass++;
  endtask

  task automatic test_ovf_cnt;
    do_reset;
    load_cfg(4'd0, 2'b10);
    IN_D      = 16'h7FFF;
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    repeat (100) tick;
    n_total++;
    if (OVF_CNT !== 16'd99) $display("FAIL cnt_rate: got %0d want 99", OVF_CNT);
    else n_pass++;
    repeat (65440) tick;
    n_total++;
    if (OVF_CNT !== 16'hFFFF) $display("FAIL cnt_sat: got %h want ffff", OVF_CNT);
    else n_pass++;
    OVF_CLR = 1'b1;
    tick;
    OVF_CLR = 1'b0;
    n_total++;
    if ({OUT_OVF, OVF_CNT} !== {1'b1, 16'h0000}) $display("FAIL cnt_clr: got ovf=%b cnt=%h want ovf=1 cnt=0000", OUT_OVF, OVF_CNT);
    else n_pass++;
    IN_VALID = 1'b0;
    repeat (3) tick;
  endtask

  initial begin
    test_reset;
    test_round;
    test_sat;
    test_fill;
    test_back_to_back;
    test_cfg;
    test_reset_mid;
    test_ovf_cnt;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
